// File: rtl/sram_cache_cu.sv
// Two-way set-associative, write-through, no-write-allocate cache between the MEM stage
// and the SRAM controller. Read hits complete combinationally; misses and writes go to SRAM.
module sram_cache_cu #(
    parameter int unsigned INDEX_BITS = 6,
    parameter int unsigned TAG_BITS   = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_rd_en,
    input  logic        mem_wr_en,
    input  logic [31:0] mem_adr,
    input  logic [31:0] mem_wr_data,
    output logic [31:0] mem_rd_data,
    output logic        mem_ready,
    output logic        sram_rd_en,
    output logic        sram_wr_en,
    output logic [31:0] sram_adr,
    output logic [31:0] sram_wr_data,
    input  logic [31:0] sram_rd_data,
    input  logic        sram_ready
);
    localparam int unsigned SETS    = 2 ** INDEX_BITS;
    localparam int unsigned TAG_LSB = 2 + INDEX_BITS;
    localparam int unsigned TAG_MSB = TAG_LSB + TAG_BITS - 1;

    typedef enum logic [1:0] {StIdle, StRdMiss, StWr} state_e;

    state_e state_q, state_d;

    logic [SETS-1:0]     valid0_q, valid0_d, valid1_q, valid1_d, lru_q, lru_d;
    logic [TAG_BITS-1:0] tag0_q  [SETS];
    logic [TAG_BITS-1:0] tag1_q  [SETS];
    logic [31:0]         data0_q [SETS];
    logic [31:0]         data1_q [SETS];

    logic [INDEX_BITS-1:0] idx;
    logic [TAG_BITS-1:0]   tag;
    logic                  hit0, hit1, hit, victim;
    logic                  we0, we1;
    logic [31:0]           wdata;
    logic                  unused_adr_bits;

    assign idx  = mem_adr[TAG_LSB-1:2];
    assign tag  = mem_adr[TAG_MSB:TAG_LSB];
    assign hit0 = valid0_q[idx] && (tag0_q[idx] == tag);
    assign hit1 = valid1_q[idx] && (tag1_q[idx] == tag);
    assign hit  = hit0 | hit1;

    // Fill an empty way first; only fall back to LRU once both ways hold data.
    assign victim = !valid0_q[idx] ? 1'b0 : (!valid1_q[idx] ? 1'b1 : lru_q[idx]);

    assign unused_adr_bits = ^{mem_adr[31:TAG_MSB+1], mem_adr[1:0]};

    always_comb begin
        state_d     = state_q;
        valid0_d    = valid0_q;
        valid1_d    = valid1_q;
        lru_d       = lru_q;
        mem_ready   = 1'b0;
        mem_rd_data = '0;
        sram_rd_en  = 1'b0;
        sram_wr_en  = 1'b0;
        we0         = 1'b0;
        we1         = 1'b0;
        wdata       = mem_wr_data;

        case (state_q)
            StIdle: begin
                if (mem_wr_en) begin
                    state_d = StWr;
                end else if (mem_rd_en) begin
                    if (hit) begin
                        mem_ready   = 1'b1;
                        mem_rd_data = hit0 ? data0_q[idx] : data1_q[idx];
                        lru_d[idx]  = hit0;
                    end else begin
                        state_d = StRdMiss;
                    end
                end else begin
                    mem_ready = 1'b1;
                end
            end
            StRdMiss: begin
                sram_rd_en = 1'b1;
                if (sram_ready) begin
                    mem_ready   = 1'b1;
                    mem_rd_data = mem_rd_en ? sram_rd_data : '0;
                    wdata       = sram_rd_data;
                    we0         = ~victim;
                    we1         = victim;
                    if (victim) valid1_d[idx] = 1'b1;
                    else        valid0_d[idx] = 1'b1;
                    lru_d[idx]  = ~victim;
                    state_d     = StIdle;
                end
            end
            StWr: begin
                sram_wr_en = 1'b1;
                if (sram_ready) begin
                    mem_ready = 1'b1;
                    state_d   = StIdle;
                    // Write-through without allocation: only an existing line is refreshed.
                    if (hit) begin
                        we0        = hit0;
                        we1        = ~hit0;
                        lru_d[idx] = hit0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign sram_adr     = (sram_rd_en || sram_wr_en) ? mem_adr : '0;
    assign sram_wr_data = mem_wr_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            valid0_q <= '0;
            valid1_q <= '0;
            lru_q    <= '0;
        end else begin
            state_q  <= state_d;
            valid0_q <= valid0_d;
            valid1_q <= valid1_d;
            lru_q    <= lru_d;
        end
    end

    // Tags and data need no reset: the valid bits gate every use.
    always_ff @(posedge clk) begin
        if (we0) begin
            tag0_q[idx]  <= tag;
            data0_q[idx] <= wdata;
        end
        if (we1) begin
            tag1_q[idx]  <= tag;
            data1_q[idx] <= wdata;
        end
    end
endmodule

// File: tb/tb_sram_cache_cu.sv
// Self-checking bench for sram_cache_cu: directed vector table, reset/idle sequences and
// randomized traffic against a behavioural cache model plus an SRAM controller model.
module tb_sram_cache_cu;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_rd_en = 1'b0;
    logic        mem_wr_en = 1'b0;
    logic [31:0] mem_adr = '0;
    logic [31:0] mem_wr_data = '0;
    logic [31:0] mem_rd_data;
    logic        mem_ready;
    logic        sram_rd_en;
    logic        sram_wr_en;
    logic [31:0] sram_adr;
    logic [31:0] sram_wr_data;
    logic [31:0] sram_rd_data;
    logic        sram_ready;

    int n_checks = 0;
    int n_errors = 0;

    sram_cache_cu dut (
        .clk          (clk),
        .rst          (rst),
        .mem_rd_en    (mem_rd_en),
        .mem_wr_en    (mem_wr_en),
        .mem_adr      (mem_adr),
        .mem_wr_data  (mem_wr_data),
        .mem_rd_data  (mem_rd_data),
        .mem_ready    (mem_ready),
        .sram_rd_en   (sram_rd_en),
        .sram_wr_en   (sram_wr_en),
        .sram_adr     (sram_adr),
        .sram_wr_data (sram_wr_data),
        .sram_rd_data (sram_rd_data),
        .sram_ready   (sram_ready)
    );

    always #5 clk = ~clk;

    // SRAM controller model: busy for sram_lat cycles after a request appears.
    int          sram_lat = 2;
    int          sram_cnt = 0;
    logic [31:0] sram_mem [2048];
    bit          written  [2048];
    logic [31:0] rd_word  = '0;

    function automatic logic [31:0] default_word(input logic [31:0] a);
        case (a)
            32'h100: return 32'hDEADBEEF;
            32'h200: return 32'h22222222;
            32'h300: return 32'h33333333;
            32'h400: return 32'h44444444;
            default: return {a[15:0], ~a[15:0]};
        endcase
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return written[a[12:2]] ? sram_mem[a[12:2]] : default_word(a);
    endfunction

    assign sram_ready   = (sram_rd_en || sram_wr_en) ? (sram_cnt >= sram_lat) : 1'b1;
    assign sram_rd_data = (sram_rd_en && sram_ready) ? rd_word : 32'h0BADF00D;

    always @(posedge clk) begin
        if (rst || !(sram_rd_en || sram_wr_en) || sram_ready) sram_cnt <= 0;
        else sram_cnt <= sram_cnt + 1;
        if (sram_rd_en && sram_cnt == 0) rd_word <= mem_word(sram_adr);
        if (!rst && sram_wr_en && sram_ready) begin
            sram_mem[sram_adr[12:2]] <= sram_wr_data;
            written[sram_adr[12:2]]  <= 1'b1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        mem_rd_en = 1'b0;
        mem_wr_en = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Called just after a rising edge; returns just after the completing edge.
    task automatic run_txn(input bit wr, input logic [31:0] adr, input logic [31:0] wdata,
                           input bit exp_hit, input logic [31:0] exp_rdata, input string name);
        int          cyc = 0;
        bit          done = 1'b0;
        bit          proto_ok = 1'b1;
        logic [31:0] got = '0;
        int          exp_cyc = (!wr && exp_hit) ? 1 : sram_lat + 2;
        mem_wr_en   = wr;
        mem_rd_en   = !wr;
        mem_adr     = adr;
        mem_wr_data = wdata;
        while (!done && cyc < 40) begin
            @(negedge clk);
            if (sram_rd_en && sram_wr_en) proto_ok = 1'b0;
            if ((sram_rd_en || sram_wr_en) && sram_adr != adr) proto_ok = 1'b0;
            if (!(sram_rd_en || sram_wr_en) && sram_adr != 0) proto_ok = 1'b0;
            if (sram_wr_data != wdata) proto_ok = 1'b0;
            if (cyc == 0 && (sram_rd_en || sram_wr_en)) proto_ok = 1'b0;
            if (cyc > 0 && (wr ? (!sram_wr_en || sram_rd_en) : (!sram_rd_en || sram_wr_en)))
                proto_ok = 1'b0;
            if ((!mem_ready || wr) && mem_rd_data != 0) proto_ok = 1'b0;
            if (mem_ready) begin
                done = 1'b1;
                got  = mem_rd_data;
            end
            cyc++;
            @(posedge clk);
            #1;
        end
        mem_rd_en = 1'b0;
        mem_wr_en = 1'b0;
        check({name, " done"}, 32'(done), 32'd1);
        check({name, " latency"}, cyc, exp_cyc);
        check({name, " protocol"}, 32'(proto_ok), 32'd1);
        if (!wr) check({name, " rdata"}, got, exp_rdata);
    endtask

    task automatic idle_cycles(input int n, input string name);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check(name, {29'd0, mem_ready, sram_rd_en, sram_wr_en}, 32'b100);
            @(posedge clk);
            #1;
        end
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] adr;
        logic [31:0] wdata;
        int          lat;
        bit          exp_hit;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t tbl [12];

    // Behavioural cache model for the randomized phase (sets 0..3 only).
    bit          m_valid [4][2];
    logic [10:0] m_tag   [4][2];
    logic [31:0] m_data  [4][2];
    bit          m_lru   [4];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        bit seen;
        tbl[0]  = '{1'b0, 32'h100, 32'h0,        2, 1'b0, 32'hDEADBEEF};
        tbl[1]  = '{1'b0, 32'h100, 32'h0,        2, 1'b1, 32'hDEADBEEF};
        tbl[2]  = '{1'b0, 32'h200, 32'h0,        1, 1'b0, 32'h22222222};
        tbl[3]  = '{1'b0, 32'h300, 32'h0,        3, 1'b0, 32'h33333333};
        tbl[4]  = '{1'b0, 32'h200, 32'h0,        1, 1'b1, 32'h22222222};
        tbl[5]  = '{1'b0, 32'h100, 32'h0,        2, 1'b0, 32'hDEADBEEF};
        tbl[6]  = '{1'b1, 32'h100, 32'h12345678, 2, 1'b1, 32'h0};
        tbl[7]  = '{1'b0, 32'h100, 32'h0,        2, 1'b1, 32'h12345678};
        tbl[8]  = '{1'b1, 32'h400, 32'hCAFEF00D, 3, 1'b0, 32'h0};
        tbl[9]  = '{1'b0, 32'h400, 32'h0,        1, 1'b0, 32'hCAFEF00D};
        tbl[10] = '{1'b0, 32'h200, 32'h0,        2, 1'b0, 32'h22222222};
        tbl[11] = '{1'b0, 32'h400, 32'h0,        2, 1'b1, 32'hCAFEF00D};

        do_reset();
        @(negedge clk);
        check("reset outputs", {28'd0, mem_ready, sram_rd_en, sram_wr_en, 1'b0}, 32'b1000);
        check("reset rdata", mem_rd_data, 32'h0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 12; i++) begin
            sram_lat = tbl[i].lat;
            run_txn(tbl[i].wr, tbl[i].adr, tbl[i].wdata, tbl[i].exp_hit, tbl[i].exp_rdata,
                    $sformatf("vec%0d", i));
        end
        check("sram word 0x100", mem_word(32'h100), 32'h12345678);
        check("sram word 0x400", mem_word(32'h400), 32'hCAFEF00D);

        // Reset in the middle of a read miss.
        do_reset();
        sram_lat = 3;
        run_txn(1'b0, 32'h100, 32'h0, 1'b0, mem_word(32'h100), "rst fill");
        run_txn(1'b0, 32'h100, 32'h0, 1'b1, mem_word(32'h100), "rst prehit");
        mem_rd_en = 1'b1;
        mem_adr   = 32'h500;
        seen      = 1'b0;
        for (int k = 0; k < 5 && !seen; k++) begin
            @(negedge clk);
            seen = sram_rd_en;
        end
        check("rst miss started", 32'(seen), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst enables", {30'd0, sram_rd_en, sram_wr_en}, 32'd0);
        check("rst rdata", mem_rd_data, 32'h0);
        check("rst ready", 32'(mem_ready), 32'd0);
        mem_rd_en = 1'b0;
        @(posedge clk);
        #1;
        idle_cycles(10, "idle");
        run_txn(1'b0, 32'h100, 32'h0, 1'b0, mem_word(32'h100), "rst reread");

        // Randomized traffic against the model.
        do_reset();
        for (int s = 0; s < 4; s++) begin
            m_valid[s][0] = 1'b0;
            m_valid[s][1] = 1'b0;
            m_lru[s]      = 1'b0;
        end
        for (int i = 0; i < 300; i++) begin
            bit          wr = ($urandom_range(0, 3) == 0);
            int          s = $urandom_range(0, 3);
            logic [10:0] t = 11'($urandom_range(1, 5));
            logic [31:0] a = {13'd0, t, 6'(s), 2'b00};
            logic [31:0] wd = $urandom;
            bit          hit = 1'b0;
            int          way = 0;
            int          vic;
            logic [31:0] exp;
            for (int w = 1; w >= 0; w--) begin
                if (m_valid[s][w] && m_tag[s][w] == t) begin
                    hit = 1'b1;
                    way = w;
                end
            end
            exp      = hit ? m_data[s][way] : mem_word(a);
            sram_lat = $urandom_range(1, 3);
            run_txn(wr, a, wd, hit, exp, $sformatf("rnd%0d", i));
            if (hit) begin
                if (wr) m_data[s][way] = wd;
                m_lru[s] = (way == 0);
            end else if (!wr) begin
                vic = !m_valid[s][0] ? 0 : (!m_valid[s][1] ? 1 : int'(m_lru[s]));
                m_valid[s][vic] = 1'b1;
                m_tag[s][vic]   = t;
                m_data[s][vic]  = exp;
                m_lru[s]        = (vic == 0);
            end
            if ($urandom_range(0, 7) == 0) idle_cycles(1, "rnd idle");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
